// File: rtl/if_fetch.sv
// Instruction-fetch front end: owns the PC and talks req/ack to imem.
// Presents if_pc/if_inst to IF/ID; one-deep hold buffer absorbs stalls.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic        flush,
  input  logic [31:0] new_pc,
  input  logic        branch_flag,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        stallreq_if
);

  typedef enum logic [1:0] {
    START,
    FETCH,
    HOLD
  } state_t;

  state_t      state;
  state_t      state_n;

  logic [31:0] pc;
  logic [31:0] pc_n;
  logic [31:0] req_addr;
  logic [31:0] req_addr_n;
  logic [31:0] hold_pc;
  logic [31:0] hold_pc_n;
  logic [31:0] hold_inst;
  logic [31:0] hold_inst_n;
  logic        hold_vld;
  logic        hold_vld_n;
  logic        drop;
  logic        drop_n;
  logic [31:0] if_pc_n;
  logic [31:0] if_inst_n;

  logic        stop;
  logic        redirect;
  logic [31:0] redir_pc;
  logic        in_fetch;
  logic        take;
  logic        new_req;

  logic        unused_stall;

  assign unused_stall = ^stall[5:1];

  assign stop     = stall[0];
  assign redirect = flush | branch_flag;
  assign redir_pc = flush ? new_pc : branch_target;
  assign in_fetch = (state == FETCH);

  // A returned word is kept only if it was not squashed.
  assign take = in_fetch & imem_ack & ~drop & ~redirect;

  assign imem_req    = in_fetch;
  assign imem_addr   = req_addr;
  assign stallreq_if = imem_req & ~imem_ack;

  // Next-state, PC, hold buffer and presented pair.
  always_comb begin
    state_n     = state;
    pc_n        = pc;
    req_addr_n  = req_addr;
    hold_pc_n   = hold_pc;
    hold_inst_n = hold_inst;
    hold_vld_n  = hold_vld;
    drop_n      = drop;
    if_pc_n     = if_pc;
    if_inst_n   = if_inst;
    new_req     = 1'b0;

    unique case (state)
      START: begin
        state_n = FETCH;
        new_req = 1'b1;
      end
      FETCH: begin
        if (imem_ack) begin
          drop_n  = 1'b0;
          new_req = 1'b1;
          if (take) begin
            pc_n = req_addr + 32'd4;
            if (stop) begin
              hold_pc_n   = req_addr;
              hold_inst_n = imem_rdata;
              hold_vld_n  = 1'b1;
              state_n     = HOLD;
              new_req     = 1'b0;
            end
          end
        end else if (redirect) begin
          drop_n = 1'b1;
        end
      end
      HOLD: begin
        if (!stop || redirect) begin
          state_n = FETCH;
          new_req = 1'b1;
        end
      end
      default: begin
        state_n = START;
      end
    endcase

    if (!stop) begin
      if (hold_vld) begin
        if_pc_n    = hold_pc;
        if_inst_n  = hold_inst;
        hold_vld_n = 1'b0;
      end else if (take) begin
        if_pc_n   = req_addr;
        if_inst_n = imem_rdata;
      end else begin
        if_pc_n   = 32'd0;
        if_inst_n = 32'd0;
      end
    end

    if (redirect) begin
      pc_n       = redir_pc;
      hold_vld_n = 1'b0;
      if_pc_n    = 32'd0;
      if_inst_n  = 32'd0;
    end

    if (new_req) begin
      req_addr_n = pc_n;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= START;
      pc        <= RESET_PC;
      req_addr  <= RESET_PC;
      hold_pc   <= 32'd0;
      hold_inst <= 32'd0;
      hold_vld  <= 1'b0;
      drop      <= 1'b0;
      if_pc     <= 32'd0;
      if_inst   <= 32'd0;
    end else begin
      state     <= state_n;
      pc        <= pc_n;
      req_addr  <= req_addr_n;
      hold_pc   <= hold_pc_n;
      hold_inst <= hold_inst_n;
      hold_vld  <= hold_vld_n;
      drop      <= drop_n;
      if_pc     <= if_pc_n;
      if_inst   <= if_inst_n;
    end
  end

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction-fetch front end that produces the if_pc/if_inst pair consumed by the IF/ID pipeline register.
- Owns the PC and runs a req/ack handshake to instruction memory, which may return data in zero or more wait cycles.
- Honours the same stall[5:0] vector and flush used downstream, accepts branch redirects from ID and exception redirects from ctrl, and raises stallreq_if while a fetch is outstanding.

Parameters:
- RESET_PC, 32'h0000_0000, address of the first fetch after reset.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- stall  in  6  pipeline stall vector; only stall[0] is used (1 = STOP for the IF stage).
- flush  in  1  exception flush; redirect to new_pc.
- new_pc  in  32  exception handler target; valid when flush=1.
- branch_flag  in  1  taken branch/jump resolved in ID (one-cycle pulse).
- branch_target  in  32  branch destination; valid when branch_flag=1.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address; stable while imem_req=1 and no ack.
- imem_ack  in  1  memory has returned imem_rdata this cycle.
- imem_rdata  in  32  instruction word.
- if_pc  out  32  PC of the presented instruction.
- if_inst  out  32  presented instruction; 0 = bubble.
- stallreq_if  out  1  requests a pipeline stall; combinational, equals imem_req & ~imem_ack.

Behaviour:
- Reset (rst=0, asynchronous):
  - pc=RESET_PC, state=START, if_pc=0, if_inst=0, imem_req=0, hold buffer empty, drop=0.
- States: START, FETCH, HOLD.
  - START: one idle cycle after reset release, then go to FETCH.
  - FETCH: imem_req=1, imem_addr=req_addr. req_addr is latched from pc on entry and held until ack.
  - HOLD: imem_req=0. A fetched word is waiting in the hold buffer.
- Consumption:
  - The presented pair is consumed at any posedge where stall[0]=0.
  - A consumed pair is replaced by the newest available pair: the hold buffer first, otherwise the ack data from that cycle, otherwise a bubble (if_pc=0, if_inst=0).
  - When stall[0]=1, if_pc and if_inst hold their values.
- Ack in FETCH with drop=0:
  - If stall[0]=0: load {req_addr, imem_rdata} directly into the outputs.
  - If stall[0]=1: store it in the hold buffer and go to HOLD.
  - pc advances to req_addr+4 (modulo 2^32, so 32'hFFFF_FFFC wraps to 0), unless a redirect occurs in the same cycle.
  - Next state is FETCH (new request the following cycle) or HOLD.
- HOLD: on the first edge with stall[0]=0, move the buffer to the outputs and return to FETCH at pc.
- Zero-wait memory: ack in the same cycle as req sustains one instruction per cycle; stallreq_if stays 0.
- Redirects:
  - Priority is flush > branch_flag > sequential.
  - pc <= flush ? new_pc : branch_target.
  - The hold buffer is cleared and the outputs become a bubble at that edge, regardless of stall[0].
  - If a request is outstanding without ack, set drop=1. The request stays asserted at its original address until ack; the returned data is discarded; drop is then cleared and the next request uses the redirected pc.
  - A redirect in the same cycle as an ack discards that data; the next request goes to the target.
  - A redirect during HOLD leaves HOLD and goes to FETCH at the target next cycle.
  - A redirect during START sets pc only; the first fetch then goes to the target.
- Alignment: addresses are used as supplied; no alignment check is made here.
- Reset during an outstanding fetch: all state clears immediately and any late ack is ignored (state is START).

Test Plan:
- Reset release, zero-wait memory returning imem_rdata=addr^32'hA5A5_0000, stall=0 → imem_addr sequence 0,4,8,…; if_pc/if_inst valid from the 3rd cycle onward, one per cycle; stallreq_if never 1.
- Memory with 2 wait cycles → stallreq_if=1 for 2 cycles per fetch; imem_addr constant during the wait; if_pc sequence 0,4,8 with bubbles between fetches.
- stall[0]=1 for 3 cycles while an ack for addr 8 arrives → if_pc stays 4; state HOLD, imem_req=0; after release if_pc=8, then the next request is to 12.
- branch_flag with branch_target=32'h100 during a 3-wait fetch of addr 0xC → 0xC request held until ack, data dropped, outputs bubble; next imem_addr=0x100, then if_pc=0x100.
- flush with new_pc=32'h80 in the same cycle as branch_flag (target 0x200) and an ack → ack data dropped; next imem_addr=0x80.
- rst asserted mid-fetch, ack arriving during reset → outputs 0 immediately; after release the first imem_addr=RESET_PC.
